// File: rtl/cdc_handshake_src.sv
// Source-side end of a toggle req/ack handshake that carries one DATA_W word
// into another clock domain. A word is accepted on in_valid & in_ready, held on
// xfer_data, and announced by flipping req_tgl. The destination's ack toggle is
// synchronized into clk_src; once it matches req_tgl the word is released.
// Optional ack timeout: define CDC_SRC_TIMEOUT_EN to add a watchdog that moves to
// a sticky error state after TIMEOUT_CYC cycles without an ack.
module cdc_handshake_src #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic              clk_src,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              req_tgl,
   output logic [DATA_W-1:0] xfer_data,
   input  logic              ack_tgl_async,
   output logic              busy,
   output logic              done_pulse,
   output logic              timeout_err
);

   // Elaboration-time parameter legality checks.
   if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("cdc_handshake_src: SYNC_STAGES must be >= 2");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cyc
      $error("cdc_handshake_src: TIMEOUT_CYC must be >= 1");
   end

`ifdef CDC_SRC_TIMEOUT_EN
   typedef enum logic [1:0] {StIdle, StWaitAck, StErr} state_e;
   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            timeout_err_q, timeout_err_d;
`else
   typedef enum logic [0:0] {StIdle, StWaitAck} state_e;
`endif

   state_e                 state_q, state_d;
   logic                   in_ready_q, in_ready_d;
   logic                   req_tgl_q, req_tgl_d;
   logic [DATA_W-1:0]      xfer_data_q, xfer_data_d;
   logic                   busy_q, busy_d;
   logic                   done_pulse_q, done_pulse_d;
   logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
   logic                   ack_s;

   // Ack synchronizer: shift the async toggle through SYNC_STAGES flops.
   always_comb begin
      ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_tgl_async};
      ack_s      = ack_sync_q[SYNC_STAGES-1];
   end

   // Next-state and output logic; every register holds unless a transition fires.
   always_comb begin
      state_d      = state_q;
      in_ready_d   = in_ready_q;
      req_tgl_d    = req_tgl_q;
      xfer_data_d  = xfer_data_q;
      busy_d       = busy_q;
      done_pulse_d = 1'b0;
`ifdef CDC_SRC_TIMEOUT_EN
      cnt_d         = cnt_q;
      timeout_err_d = timeout_err_q;
`endif
      case (state_q)
         StIdle: begin
            if (in_valid && in_ready_q) begin
               // Data and toggle move together; the far side reads data only
               // after it has seen the toggle, so no extra qualification needed.
               xfer_data_d = in_data;
               req_tgl_d   = ~req_tgl_q;
               state_d     = StWaitAck;
               in_ready_d  = 1'b0;
               busy_d      = 1'b1;
`ifdef CDC_SRC_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end else begin
               // Raises in_ready on the first edge after reset; otherwise holds.
               // A stray ack change here is deliberately ignored.
               in_ready_d = 1'b1;
            end
         end
         StWaitAck: begin
            // A match on the same edge as the timeout limit completes normally.
            if (ack_s == req_tgl_q) begin
               state_d      = StIdle;
               busy_d       = 1'b0;
               done_pulse_d = 1'b1;
               in_ready_d   = 1'b1;
`ifdef CDC_SRC_TIMEOUT_EN
            end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
               cnt_d         = cnt_q + CntW'(1);
               state_d       = StErr;
               timeout_err_d = 1'b1;
               busy_d        = 1'b0;
               in_ready_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
`endif
            end
         end
`ifdef CDC_SRC_TIMEOUT_EN
         StErr: begin
            // Only reset leaves the error state.
            in_ready_d = 1'b0;
            busy_d     = 1'b0;
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with asynchronous active-high reset.
   always_ff @(posedge clk_src or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         in_ready_q   <= 1'b0;
         req_tgl_q    <= 1'b0;
         xfer_data_q  <= '0;
         busy_q       <= 1'b0;
         done_pulse_q <= 1'b0;
         ack_sync_q   <= '0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         req_tgl_q    <= req_tgl_d;
         xfer_data_q  <= xfer_data_d;
         busy_q       <= busy_d;
         done_pulse_q <= done_pulse_d;
         ack_sync_q   <= ack_sync_d;
      end
   end

`ifdef CDC_SRC_TIMEOUT_EN
   // Timeout counter and sticky error flag.
   always_ff @(posedge clk_src or posedge reset) begin
      if (reset) begin
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign in_ready   = in_ready_q;
   assign req_tgl    = req_tgl_q;
   assign xfer_data  = xfer_data_q;
   assign busy       = busy_q;
   assign done_pulse = done_pulse_q;

endmodule
